// File: rtl/if_stage.sv
// if_stage: instruction-fetch stage of the 16-bit pipelined processor.
// Owns the fetch PC, talks to instruction memory over a req/ack handshake,
// and loads the IF/ID register consumed by decode. A one-entry skid buffer
// catches an instruction that returns while decode is stalled; the DROP
// state discards a request that was still in flight when a branch was taken.
//
// Ports:
//   clk, rst_n        rising-edge clock, asynchronous active-low reset
//   hazard_detected   decode stall, IF/ID holds
//   Branch/Branch_PC  taken redirect from decode (ignored while stalled)
//   o_imem_req/addr   fetch request and word address (combinational req)
//   i_imem_ack/data   response for the current request
//   o_IR/o_PC/o_valid IF/ID pipeline register
module if_stage #(
  parameter logic [15:0] RESET_PC = 16'h0000,
  parameter logic [31:0] NOP_IR   = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        hazard_detected,
  input  logic        Branch,
  input  logic [15:0] Branch_PC,
  output logic        o_imem_req,
  output logic [15:0] o_imem_addr,
  input  logic        i_imem_ack,
  input  logic [31:0] i_imem_data,
  output logic [31:0] o_IR,
  output logic [15:0] o_PC,
  output logic        o_valid
);

  localparam int unsigned AW = 16;
  localparam int unsigned DW = 32;

  localparam logic [0:0] S_FETCH = 1'b0;
  localparam logic [0:0] S_DROP  = 1'b1;

  logic [0:0]    r_state;
  logic [AW-1:0] r_fetch_pc;
  logic [AW-1:0] r_redirect_pc;
  logic          r_outstanding;
  logic          r_skid_valid;
  logic [DW-1:0] r_skid_ir;
  logic [AW-1:0] r_skid_pc;
  logic [DW-1:0] r_ir;
  logic [AW-1:0] r_pc;
  logic          r_valid;

  logic [0:0]    w_state_nxt;
  logic [AW-1:0] w_fetch_pc_nxt;
  logic [AW-1:0] w_redirect_pc_nxt;
  logic          w_outstanding_nxt;
  logic          w_skid_valid_nxt;
  logic [DW-1:0] w_skid_ir_nxt;
  logic [AW-1:0] w_skid_pc_nxt;
  logic [DW-1:0] w_ir_nxt;
  logic [AW-1:0] w_pc_nxt;
  logic          w_valid_nxt;

  logic          w_req;
  logic          w_br;
  logic          w_drop_done;
  logic          w_br_taken;
  logic          w_loaded;
  logic [AW-1:0] w_pc_inc;

  // A request stays up while draining a dropped fetch, while one is pending,
  // or whenever there is room for a new instruction.
  assign w_req       = (r_state == S_DROP) | r_outstanding | (!r_skid_valid & !hazard_detected);
  assign w_br        = Branch & !hazard_detected;
  assign w_drop_done = (r_state == S_DROP) & i_imem_ack;
  // Completing a drop takes priority over a branch on the same edge.
  assign w_br_taken  = w_br & !w_drop_done;
  assign w_pc_inc    = r_fetch_pc + AW'(1);

  assign o_imem_req  = w_req;
  assign o_imem_addr = r_fetch_pc;
  assign o_IR        = r_ir;
  assign o_PC        = r_pc;
  assign o_valid     = r_valid;

  // Next-state and IF/ID next values
  always_comb begin
    w_state_nxt       = r_state;
    w_fetch_pc_nxt    = r_fetch_pc;
    w_redirect_pc_nxt = r_redirect_pc;
    w_outstanding_nxt = r_outstanding;
    w_skid_valid_nxt  = r_skid_valid;
    w_skid_ir_nxt     = r_skid_ir;
    w_skid_pc_nxt     = r_skid_pc;
    w_ir_nxt          = r_ir;
    w_pc_nxt          = r_pc;
    w_valid_nxt       = r_valid;
    w_loaded          = 1'b0;

    if (w_drop_done) begin
      // Dropped request finally returned: discard it and go to the target.
      w_fetch_pc_nxt    = r_redirect_pc;
      w_state_nxt       = S_FETCH;
      w_outstanding_nxt = 1'b0;
    end else if (w_br_taken) begin
      w_ir_nxt         = NOP_IR;
      w_valid_nxt      = 1'b0;
      w_skid_valid_nxt = 1'b0;
      if (w_req && !i_imem_ack) begin
        // Address must stay stable until ack, so park the target.
        w_state_nxt       = S_DROP;
        w_redirect_pc_nxt = Branch_PC;
      end else begin
        w_fetch_pc_nxt    = Branch_PC;
        w_outstanding_nxt = 1'b0;
      end
    end else if ((r_state == S_FETCH) && w_req && i_imem_ack) begin
      w_fetch_pc_nxt    = w_pc_inc;
      w_outstanding_nxt = 1'b0;
      if (!hazard_detected && !r_skid_valid) begin
        w_ir_nxt    = i_imem_data;
        w_pc_nxt    = w_pc_inc;
        w_valid_nxt = 1'b1;
        w_loaded    = 1'b1;
      end else begin
        w_skid_ir_nxt    = i_imem_data;
        w_skid_pc_nxt    = w_pc_inc;
        w_skid_valid_nxt = 1'b1;
      end
    end else if (w_req && !i_imem_ack) begin
      w_outstanding_nxt = 1'b1;
    end

    // IF/ID advance when not flushed: skid first, otherwise bubble.
    if (!w_br_taken && !hazard_detected) begin
      if (r_skid_valid) begin
        w_ir_nxt         = r_skid_ir;
        w_pc_nxt         = r_skid_pc;
        w_valid_nxt      = 1'b1;
        w_skid_valid_nxt = 1'b0;
      end else if (!w_loaded) begin
        w_ir_nxt    = NOP_IR;
        w_valid_nxt = 1'b0;
      end
    end
  end

  // State registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= S_FETCH;
      r_fetch_pc    <= RESET_PC;
      r_redirect_pc <= '0;
      r_outstanding <= 1'b0;
      r_skid_valid  <= 1'b0;
      r_skid_ir     <= NOP_IR;
      r_skid_pc     <= '0;
      r_ir          <= NOP_IR;
      r_pc          <= '0;
      r_valid       <= 1'b0;
    end else begin
      r_state       <= w_state_nxt;
      r_fetch_pc    <= w_fetch_pc_nxt;
      r_redirect_pc <= w_redirect_pc_nxt;
      r_outstanding <= w_outstanding_nxt;
      r_skid_valid  <= w_skid_valid_nxt;
      r_skid_ir     <= w_skid_ir_nxt;
      r_skid_pc     <= w_skid_pc_nxt;
      r_ir          <= w_ir_nxt;
      r_pc          <= w_pc_nxt;
      r_valid       <= w_valid_nxt;
    end
  end

endmodule
